// File: rtl/z80_alu_8.sv
// Z80-style 8-bit ALU: 16 functions plus the Z80 flag byte, with the result and
// flags registered together for a fixed one-cycle latency.
module z80_alu_8 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] opcode,
    input  logic       carry_in,
    output logic [7:0] out,
    output logic [7:0] flags
);

    typedef enum logic [3:0] {
        OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
        OP_XOR = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_CP  = 4'h7,
        OP_INC = 4'h8, OP_DEC = 4'h9, OP_RLC = 4'hA, OP_RRC = 4'hB,
        OP_RL  = 4'hC, OP_RR  = 4'hD, OP_SLA = 4'hE, OP_SRL = 4'hF
    } alu_op_e;

    function automatic logic parity_even(input logic [7:0] v);
        return ~(^v);
    endfunction

    logic       sub_sel_s;
    logic       cin_eff_s;
    logic [7:0] b_eff_s;
    logic [8:0] add_full_s;
    logic [4:0] add_half_s;
    logic [8:0] sub_full_s;
    logic [4:0] sub_half_s;
    logic       add_ov_s;
    logic       sub_ov_s;
    logic [7:0] res_s;
    logic       h_s;
    logic       pv_s;
    logic       n_s;
    logic       c_s;
    logic [7:0] out_s;
    logic [7:0] flags_s;

    // Shared adder/subtractor operand selection; INC/DEC reuse it with b=1, no carry.
    always_comb begin
        sub_sel_s = 1'b0;
        cin_eff_s = 1'b0;
        b_eff_s   = b;
        case (alu_op_e'(opcode))
            OP_ADD:  begin sub_sel_s = 1'b0; cin_eff_s = 1'b0;     b_eff_s = b;     end
            OP_ADC:  begin sub_sel_s = 1'b0; cin_eff_s = carry_in; b_eff_s = b;     end
            OP_SUB:  begin sub_sel_s = 1'b1; cin_eff_s = 1'b0;     b_eff_s = b;     end
            OP_SBC:  begin sub_sel_s = 1'b1; cin_eff_s = carry_in; b_eff_s = b;     end
            OP_CP:   begin sub_sel_s = 1'b1; cin_eff_s = 1'b0;     b_eff_s = b;     end
            OP_INC:  begin sub_sel_s = 1'b0; cin_eff_s = 1'b0;     b_eff_s = 8'h01; end
            OP_DEC:  begin sub_sel_s = 1'b1; cin_eff_s = 1'b0;     b_eff_s = 8'h01; end
            default: begin sub_sel_s = 1'b0; cin_eff_s = 1'b0;     b_eff_s = b;     end
        endcase
    end

    // Full and low-nibble sums/differences; bit 8 / bit 4 are the carry or borrow.
    always_comb begin
        add_full_s = {1'b0, a} + {1'b0, b_eff_s} + {8'h00, cin_eff_s};
        add_half_s = {1'b0, a[3:0]} + {1'b0, b_eff_s[3:0]} + {4'h0, cin_eff_s};
        sub_full_s = {1'b0, a} - {1'b0, b_eff_s} - {8'h00, cin_eff_s};
        sub_half_s = {1'b0, a[3:0]} - {1'b0, b_eff_s[3:0]} - {4'h0, cin_eff_s};
        add_ov_s   = (a[7] == b_eff_s[7]) && (add_full_s[7] != a[7]);
        sub_ov_s   = (a[7] != b_eff_s[7]) && (sub_full_s[7] != a[7]);
    end

    // Function select and per-class flag rules.
    always_comb begin
        res_s = 8'h00;
        h_s   = 1'b0;
        pv_s  = 1'b0;
        n_s   = 1'b0;
        c_s   = 1'b0;
        out_s = 8'h00;
        case (alu_op_e'(opcode))
            OP_ADD, OP_ADC: begin
                res_s = add_full_s[7:0]; h_s = add_half_s[4]; pv_s = add_ov_s;
                n_s = 1'b0; c_s = add_full_s[8];
            end
            OP_SUB, OP_SBC, OP_CP: begin
                res_s = sub_full_s[7:0]; h_s = sub_half_s[4]; pv_s = sub_ov_s;
                n_s = 1'b1; c_s = sub_full_s[8];
            end
            OP_INC: begin
                res_s = add_full_s[7:0]; h_s = add_half_s[4]; pv_s = add_ov_s;
                n_s = 1'b0; c_s = carry_in;
            end
            OP_DEC: begin
                res_s = sub_full_s[7:0]; h_s = sub_half_s[4]; pv_s = sub_ov_s;
                n_s = 1'b1; c_s = carry_in;
            end
            OP_AND: begin
                res_s = a & b; h_s = 1'b1; pv_s = parity_even(a & b); n_s = 1'b0; c_s = 1'b0;
            end
            OP_OR: begin
                res_s = a | b; h_s = 1'b0; pv_s = parity_even(a | b); n_s = 1'b0; c_s = 1'b0;
            end
            OP_XOR: begin
                res_s = a ^ b; h_s = 1'b0; pv_s = parity_even(a ^ b); n_s = 1'b0; c_s = 1'b0;
            end
            OP_RLC: begin res_s = {a[6:0], a[7]};     c_s = a[7]; pv_s = parity_even(res_s); end
            OP_RRC: begin res_s = {a[0], a[7:1]};     c_s = a[0]; pv_s = parity_even(res_s); end
            OP_RL:  begin res_s = {a[6:0], carry_in}; c_s = a[7]; pv_s = parity_even(res_s); end
            OP_RR:  begin res_s = {carry_in, a[7:1]}; c_s = a[0]; pv_s = parity_even(res_s); end
            OP_SLA: begin res_s = {a[6:0], 1'b0};     c_s = a[7]; pv_s = parity_even(res_s); end
            OP_SRL: begin res_s = {1'b0, a[7:1]};     c_s = a[0]; pv_s = parity_even(res_s); end
            default: begin
                res_s = 8'h00; h_s = 1'b0; pv_s = 1'b0; n_s = 1'b0; c_s = 1'b0;
            end
        endcase
        // CP keeps the accumulator; its flags still come from a-b.
        if (alu_op_e'(opcode) == OP_CP) begin
            out_s = a;
        end else begin
            out_s = res_s;
        end
        flags_s = {res_s[7], (res_s == 8'h00), 1'b0, h_s, 1'b0, pv_s, n_s, c_s};
    end

    // Output register; synchronous reset wins over any op presented that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out   <= 8'h00;
            flags <= 8'h00;
        end else begin
            out   <= out_s;
            flags <= flags_s;
        end
    end

endmodule

// File: tb/tb_z80_alu_8.sv
// Bench for z80_alu_8: directed vector table, reset sequences, and randomized
// vectors checked against an integer-arithmetic reference model.
module tb_z80_alu_8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] opcode;
    logic       carry_in;
    logic [7:0] out;
    logic [7:0] flags;

    int n_checks = 0;
    int n_pass   = 0;

    z80_alu_8 dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .opcode(opcode),
        .carry_in(carry_in), .out(out), .flags(flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic       cin;
        logic [7:0] exp_out;
        logic [7:0] exp_flags;
    } vec_t;

    function automatic int to_signed8(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    function automatic int ones(input int v);
        int n = 0;
        for (int i = 0; i < 8; i++) n += (v >> i) & 1;
        return n;
    endfunction

    // Reference model: returns {out, flags}.
    function automatic logic [15:0] model(input int av, input int bv, input int op, input int ci);
        int r = 0, res = 0, o = 0;
        int s = 0, z = 0, h = 0, pv = 0, n = 0, c = 0;
        int sr;
        case (op)
            0, 5: begin
                r  = av + bv + ((op == 5) ? ci : 0);
                h  = ((av % 16) + (bv % 16) + ((op == 5) ? ci : 0)) > 15;
                sr = to_signed8(av) + to_signed8(bv) + ((op == 5) ? ci : 0);
                pv = (sr > 127) || (sr < -128);
                c  = r > 255;
            end
            1, 6, 7: begin
                r  = av - bv - ((op == 6) ? ci : 0);
                h  = ((av % 16) - (bv % 16) - ((op == 6) ? ci : 0)) < 0;
                sr = to_signed8(av) - to_signed8(bv) - ((op == 6) ? ci : 0);
                pv = (sr > 127) || (sr < -128);
                n  = 1;
                c  = r < 0;
            end
            2: begin r = av & bv; h = 1; end
            3: r = av | bv;
            4: r = av ^ bv;
            8: begin r = av + 1; h = (av % 16) == 15; pv = (av == 127); c = ci; end
            9: begin r = av - 1; h = (av % 16) == 0;  pv = (av == 128); n = 1; c = ci; end
            10: begin r = av * 2 + av / 128;          c = av / 128; end
            11: begin r = av / 2 + (av % 2) * 128;   c = av % 2; end
            12: begin r = av * 2 + ci;                c = av / 128; end
            13: begin r = av / 2 + ci * 128;         c = av % 2; end
            14: begin r = av * 2;                     c = av / 128; end
            default: begin r = av / 2;               c = av % 2; end
        endcase
        res = ((r % 256) + 256) % 256;
        if (op inside {2, 3, 4, 10, 11, 12, 13, 14, 15}) pv = (ones(res) % 2) == 0;
        s = res >= 128;
        z = res == 0;
        o = (op == 7) ? av : res;
        return {o[7:0], s[0], z[0], 1'b0, h[0], 1'b0, pv[0], n[0], c[0]};
    endfunction

    task automatic check(input string name, input logic [7:0] exp_o, input logic [7:0] exp_f);
        n_checks++;
        if (out === exp_o && flags === exp_f) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got out=%02h flags=%02h, expected out=%02h flags=%02h",
                     name, out, flags, exp_o, exp_f);
        end
    endtask

    task automatic apply(input logic r, input logic [7:0] av, input logic [7:0] bv,
                         input logic [3:0] op, input logic ci);
        @(negedge clk);
        rst = r; a = av; b = bv; opcode = op; carry_in = ci;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        logic [15:0] exp;
        logic [7:0]  ra, rb;
        logic [3:0]  rop;
        logic        rci;

        vecs.push_back('{8'h07, 8'h07, 4'h0, 1'b0, 8'h0E, 8'h00});
        vecs.push_back('{8'h07, 8'h07, 4'h1, 1'b0, 8'h00, 8'h42});
        vecs.push_back('{8'h0D, 8'h07, 4'h2, 1'b0, 8'h05, 8'h14});
        vecs.push_back('{8'hCB, 8'h2B, 4'h3, 1'b0, 8'hEB, 8'h84});
        vecs.push_back('{8'h7F, 8'h01, 4'h0, 1'b0, 8'h80, 8'h94});
        vecs.push_back('{8'hFF, 8'h01, 4'h0, 1'b0, 8'h00, 8'h51});
        vecs.push_back('{8'hFF, 8'hFF, 4'h4, 1'b0, 8'h00, 8'h44});
        vecs.push_back('{8'h0F, 8'h00, 4'h5, 1'b1, 8'h10, 8'h10});
        vecs.push_back('{8'h00, 8'h00, 4'h6, 1'b1, 8'hFF, 8'h93});
        vecs.push_back('{8'h05, 8'h10, 4'h7, 1'b0, 8'h05, 8'h83});
        vecs.push_back('{8'h7F, 8'h00, 4'h8, 1'b0, 8'h80, 8'h94});
        vecs.push_back('{8'h80, 8'h00, 4'h9, 1'b1, 8'h7F, 8'h17});
        vecs.push_back('{8'h01, 8'h00, 4'h9, 1'b0, 8'h00, 8'h42});
        vecs.push_back('{8'h81, 8'h00, 4'hA, 1'b0, 8'h03, 8'h05});
        vecs.push_back('{8'h01, 8'h00, 4'hB, 1'b0, 8'h80, 8'h81});
        vecs.push_back('{8'h80, 8'h00, 4'hC, 1'b1, 8'h01, 8'h01});
        vecs.push_back('{8'h01, 8'h00, 4'hD, 1'b0, 8'h00, 8'h45});
        vecs.push_back('{8'h80, 8'h00, 4'hE, 1'b0, 8'h00, 8'h45});
        vecs.push_back('{8'h03, 8'h00, 4'hF, 1'b0, 8'h01, 8'h01});

        rst = 1'b1; a = 8'h00; b = 8'h00; opcode = 4'h0; carry_in = 1'b0;
        apply(1'b1, 8'h00, 8'h00, 4'h0, 1'b0);
        check("reset_state", 8'h00, 8'h00);

        foreach (vecs[i]) begin
            apply(1'b0, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].cin);
            check($sformatf("vec%0d_op%0h", i, vecs[i].op), vecs[i].exp_out, vecs[i].exp_flags);
        end

        // Reset held with a live op, then released.
        apply(1'b1, 8'hFF, 8'hFF, 4'h0, 1'b0);
        check("rst_overrides_op", 8'h00, 8'h00);
        apply(1'b0, 8'hFF, 8'hFF, 4'h0, 1'b0);
        check("rst_release", 8'hFE, 8'h91);

        // Back-to-back ops: each cycle's result reflects only that cycle's inputs.
        apply(1'b0, 8'h81, 8'h00, 4'hA, 1'b0);
        check("b2b_rlc", 8'h03, 8'h05);
        apply(1'b0, 8'h07, 8'h07, 4'h1, 1'b0);
        check("b2b_sub", 8'h00, 8'h42);

        for (int i = 0; i < 400; i++) begin
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            rop = 4'($urandom_range(0, 15));
            rci = 1'($urandom_range(0, 1));
            apply(1'b0, ra, rb, rop, rci);
            exp = model(int'(ra), int'(rb), int'(rop), int'(rci));
            check($sformatf("rand%0d_op%0h_a%02h_b%02h_c%0d", i, rop, ra, rb, rci),
                  exp[15:8], exp[7:0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
